posit_regime_detect: RTL and testbench

POSIT_REGIME_DETECT -- requirements
Module: posit_regime_detect

---
 rtl/posit_pkg.sv | 21 ++
 rtl/run_len_count.sv | 26 ++
 rtl/posit_regime_detect.sv | 135 +++++++++++++
 tb/tb_posit_regime_detect.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared posit constants and types for the regime-detect front end.
// Widths of the run length and regime fields are fixed here so downstream stages agree.
package posit_pkg;

    localparam int POSIT_N  = 32;
    localparam int POSIT_ES = 3;
    localparam int K_W      = 5;
    localparam int REG_W    = 6;

    localparam logic [POSIT_N-1:0] ZERO_PAT = 32'h0000_0000;
    localparam logic [POSIT_N-1:0] NAR_PAT  = 32'h8000_0000;

    typedef logic [K_W-1:0]          run_len_t;
    typedef logic signed [REG_W-1:0] regime_t;

    // A run of ones encodes m-1, a run of zeros encodes -m.
    function automatic regime_t regime_of(input logic lead, input run_len_t m);
        return lead ? (regime_t'(m) - regime_t'(1)) : -regime_t'(m);
    endfunction

endpackage

// File: rtl/run_len_count.sv
// Combinational regime run-length counter: number of consecutive bits equal
// to the MSB of the body, scanning from the MSB downward.
module run_len_count
    import posit_pkg::*;
#(
    parameter int W = POSIT_N - 1
) (
    input  logic [W-1:0] body,
    output run_len_t     m
);

    logic run;

    always_comb begin
        m   = '0;
        run = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            if (run && (body[i] == body[W-1])) begin
                m = m + run_len_t'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/posit_regime_detect.sv
// Two-stage posit front end: stage 1 takes sign/magnitude and special flags,
// stage 2 measures the regime run and its signed value. Valid/ready on both sides.
module posit_regime_detect
    import posit_pkg::*;
#(
    parameter int N  = POSIT_N,
    parameter int ES = POSIT_ES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            in_posit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sign,
    output logic [N-2:0]            out_body,
    output logic [K_W-1:0]          out_k,
    output logic signed [REG_W-1:0] out_regime,
    output logic                    out_zero,
    output logic                    out_nar
);

    if (N < 3 || N > POSIT_N || ES < 0 || ES > N - 3 || (N - 1) >= (1 << K_W)) begin : g_param_check
        $error("posit_regime_detect: unsupported N/ES combination");
    end

    localparam logic [N-1:0] ZERO_P = ZERO_PAT[POSIT_N-1 -: N];
    localparam logic [N-1:0] NAR_P  = NAR_PAT[POSIT_N-1 -: N];

    logic         s1_valid;
    logic         s1_sign;
    logic [N-2:0] s1_body;
    logic         s1_zero;
    logic         s1_nar;

    logic         s2_valid;
    logic         s2_sign;
    logic [N-2:0] s2_body;
    run_len_t     s2_k;
    regime_t      s2_regime;
    logic         s2_zero;
    logic         s2_nar;

    logic         s1_load;
    logic         s2_load;
    logic         in_zero;
    logic         in_nar;
    logic [N-2:0] neg_body;
    logic [N-2:0] in_body;
    run_len_t     run_m;
    run_len_t     next_k;
    regime_t      next_regime;

    assign s2_load  = s1_valid && (!s2_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign s1_load  = in_valid && in_ready;

    // Low N-1 bits of the two's complement only depend on the low N-1 input bits.
    assign neg_body = ~in_posit[N-2:0] + {{(N-2){1'b0}}, 1'b1};
    assign in_zero  = (in_posit == ZERO_P);
    assign in_nar   = (in_posit == NAR_P);
    assign in_body  = (in_zero || in_nar) ? '0
                    : (in_posit[N-1] ? neg_body : in_posit[N-2:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_body  <= '0;
            s1_zero  <= 1'b0;
            s1_nar   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s1_load) begin
                s1_sign <= in_posit[N-1];
                s1_body <= in_body;
                s1_zero <= in_zero;
                s1_nar  <= in_nar;
            end
        end
    end

    run_len_count #(
        .W (N - 1)
    ) u_run_len_count (
        .body (s1_body),
        .m    (run_m)
    );

    // Zero and NaR have an all-zero body, which would otherwise read as a maximal zero run.
    always_comb begin
        next_k      = run_m;
        next_regime = regime_of(s1_body[N-2], run_m);
        if (s1_zero || s1_nar) begin
            next_k      = '0;
            next_regime = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_body   <= '0;
            s2_k      <= '0;
            s2_regime <= '0;
            s2_zero   <= 1'b0;
            s2_nar    <= 1'b0;
        end else begin
            if (!s2_valid || out_ready) begin
                s2_valid <= s1_valid;
            end
            if (s2_load) begin
                s2_sign   <= s1_sign;
                s2_body   <= s1_body;
                s2_k      <= next_k;
                s2_regime <= next_regime;
                s2_zero   <= s1_zero;
                s2_nar    <= s1_nar;
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_sign   = s2_sign;
    assign out_body   = s2_body;
    assign out_k      = s2_k;
    assign out_regime = s2_regime;
    assign out_zero   = s2_zero;
    assign out_nar    = s2_nar;

endmodule

// File: tb/tb_posit_regime_detect.sv
// Bench for posit_regime_detect: directed vector table, stall and reset
// sequences, then a randomized stream scored against an arithmetic model.
module tb_posit_regime_detect;
    import posit_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [31:0]             in_posit;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_sign;
    logic [30:0]             out_body;
    logic [4:0]              out_k;
    logic signed [5:0]       out_regime;
    logic                    out_zero;
    logic                    out_nar;

    always #5 clk = ~clk;

    posit_regime_detect #(.N(32), .ES(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_posit   (in_posit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_body   (out_body),
        .out_k      (out_k),
        .out_regime (out_regime),
        .out_zero   (out_zero),
        .out_nar    (out_nar)
    );

    typedef struct packed {
        logic              sign;
        logic [30:0]       body;
        logic [4:0]        k;
        logic signed [5:0] regime;
        logic              zero;
        logic              nar;
    } res_t;

    typedef struct {
        logic [31:0] posit;
        res_t        exp;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    res_t sbq[$];
    int   delivered;

    function automatic int bitlen(input longint unsigned v);
        int n = 0;
        while (v != 0) begin
            v = v >> 1;
            n++;
        end
        return n;
    endfunction

    // Magnitude by modular negation; run length from bit lengths of body or its complement.
    function automatic res_t model(input logic [31:0] p);
        res_t            r;
        longint unsigned mag;
        longint unsigned b;
        int              m;
        r = '0;
        r.sign = p[31];
        if (p == 32'h0000_0000) begin
            r.zero = 1'b1;
            return r;
        end
        if (p == 32'h8000_0000) begin
            r.nar = 1'b1;
            return r;
        end
        mag = p[31] ? (64'h1_0000_0000 - longint'(p)) : longint'(p);
        b   = mag & 64'h7FFF_FFFF;
        r.body = b[30:0];
        if (b >= 64'h4000_0000) begin
            m = 31 - bitlen(64'h7FFF_FFFF - b);
            r.regime = 6'(m - 1);
        end else begin
            m = 31 - bitlen(b);
            r.regime = 6'(-m);
        end
        r.k = 5'(m);
        return r;
    endfunction

    function automatic res_t dut_res();
        return '{out_sign, out_body, out_k, out_regime, out_zero, out_nar};
    endfunction

    task automatic check_res(input string name, input res_t got, input res_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got sign=%0b body=%h k=%0d regime=%0d zero=%0b nar=%0b, want sign=%0b body=%h k=%0d regime=%0d zero=%0b nar=%0b",
                     name, got.sign, got.body, got.k, got.regime, got.zero, got.nar,
                     exp.sign, exp.body, exp.k, exp.regime, exp.zero, exp.nar);
        end
    endtask

    task automatic check_val(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    // One cycle from posedge+1: drive, score handshakes, clock, then verify any held output.
    task automatic step(input logic iv, input logic [31:0] p, input logic ordy,
                        output logic acc, output logic rdy);
        logic hold;
        res_t snap;
        in_valid  = iv;
        in_posit  = p;
        out_ready = ordy;
        #1;
        rdy  = in_ready;
        acc  = iv && in_ready;
        hold = out_valid && !out_ready;
        snap = dut_res();
        if (acc) sbq.push_back(model(p));
        if (out_valid && out_ready) begin
            delivered++;
            if (sbq.size() == 0) begin
                check_val("unexpected_output", 1, 0);
            end else begin
                check_res("stream", dut_res(), sbq.pop_front());
            end
        end
        @(posedge clk);
        #1;
        if (hold) begin
            check_val("hold_valid", out_valid, 1);
            check_res("hold_data", dut_res(), snap);
        end
    endtask

    vec_t vecs[9];

    initial begin
        logic        acc;
        logic        rdy;
        logic        saw_low;
        int          idx;
        logic [31:0] w[4];
        logic [31:0] specials[8];

        vecs[0] = '{32'h4000_0000, '{1'b0, 31'h4000_0000, 5'd1,  6'sd0,   1'b0, 1'b0}};
        vecs[1] = '{32'hC000_0000, '{1'b1, 31'h4000_0000, 5'd1,  6'sd0,   1'b0, 1'b0}};
        vecs[2] = '{32'h7FFF_FFFF, '{1'b0, 31'h7FFF_FFFF, 5'd31, 6'sd30,  1'b0, 1'b0}};
        vecs[3] = '{32'h0000_0001, '{1'b0, 31'h0000_0001, 5'd30, -6'sd30, 1'b0, 1'b0}};
        vecs[4] = '{32'h0000_0000, '{1'b0, 31'h0000_0000, 5'd0,  6'sd0,   1'b1, 1'b0}};
        vecs[5] = '{32'h8000_0000, '{1'b1, 31'h0000_0000, 5'd0,  6'sd0,   1'b0, 1'b1}};
        vecs[6] = '{32'h2000_0000, '{1'b0, 31'h2000_0000, 5'd1,  -6'sd1,  1'b0, 1'b0}};
        vecs[7] = '{32'hFFFF_FFFF, '{1'b1, 31'h0000_0001, 5'd30, -6'sd30, 1'b0, 1'b0}};
        vecs[8] = '{32'h6000_0000, '{1'b0, 31'h6000_0000, 5'd2,  6'sd1,   1'b0, 1'b0}};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_posit  = '0;
        out_ready = 1'b1;
        delivered = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("reset_out_valid", out_valid, 0);
        check_val("reset_in_ready", in_ready, 1);
        check_res("reset_fields", dut_res(), '0);

        // Directed table: single word, checked for latency and fields.
        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            in_valid  = 1'b1;
            in_posit  = vecs[i].posit;
            out_ready = 1'b1;
            #1;
            check_val($sformatf("vec%0d_in_ready", i), in_ready, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check_val($sformatf("vec%0d_early", i), out_valid, 0);
            @(posedge clk);
            #1;
            check_val($sformatf("vec%0d_valid", i), out_valid, 1);
            check_res($sformatf("vec%0d", i), dut_res(), vecs[i].exp);
        end
        @(posedge clk);
        #1;
        check_val("table_drained", out_valid, 0);

        // Four back-to-back words with out_ready low on cycles 3..5.
        w[0] = 32'h1234_5678;
        w[1] = 32'hF000_0001;
        w[2] = 32'h7000_0000;
        w[3] = 32'h8000_0000;
        idx = 0;
        saw_low = 1'b0;
        delivered = 0;
        sbq.delete();
        for (int c = 0; c < 14; c++) begin
            step(idx < 4, w[idx % 4], !(c >= 3 && c <= 5), acc, rdy);
            if (!rdy) saw_low = 1'b1;
            if (acc) idx++;
        end
        check_val("stall_accepted", idx, 4);
        check_val("stall_delivered", delivered, 4);
        check_val("stall_in_ready_low", saw_low, 1);
        check_val("stall_queue_empty", sbq.size(), 0);

        // Reset one cycle after accepting a word: the word must vanish.
        in_valid  = 1'b1;
        in_posit  = 32'h5555_0000;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("midrst_out_valid", out_valid, 0);
        check_val("midrst_in_ready", in_ready, 1);
        check_res("midrst_fields", dut_res(), '0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("midrst_silent%0d", c), out_valid, 0);
        end

        // Randomized stream with random backpressure.
        specials[0] = 32'h0000_0000; specials[1] = 32'h8000_0000;
        specials[2] = 32'h7FFF_FFFF; specials[3] = 32'h0000_0001;
        specials[4] = 32'hFFFF_FFFF; specials[5] = 32'h8000_0001;
        specials[6] = 32'h4000_0000; specials[7] = 32'hC000_0000;
        sbq.delete();
        delivered = 0;
        for (int c = 0; c < 2000; c++) begin
            logic [31:0] p;
            p = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
            step($urandom_range(0, 3) != 0, p, $urandom_range(0, 9) < 7, acc, rdy);
        end
        for (int c = 0; c < 20 && sbq.size() != 0; c++) begin
            step(1'b0, 32'h0, 1'b1, acc, rdy);
        end
        check_val("random_drained", sbq.size(), 0);
        check_val("random_some_delivered", delivered > 500, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
